led_fader: RTL and testbench
============================

# led_fader

Per-LED brightness fader and PWM driver sitting directly downstream of `light`. It consumes the 16-bit on/off pattern that `light` produces and drives the board LEDs (`ledr`) with PWM. Each bit fades smoothly between 0 and a programmable maximum brightness instead of switching hard. The top level instantiates it between `light` and the `ledr` output.

## Interface
- `N_LED`, 16: number of LED channels.
- `PWM_BITS`, 8: brightness and PWM resolution.
- `PRESCALE`, 1000: clocks per fade tick (≥2).
- `FADE_STEP`, 8: level change per tick (1..2^PWM_BITS-1).
- `clk`  in  1: single clock; all state on rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `enable`  in  1: 0 forces outputs dark and clears levels.
- `led_in`  in  N_LED: target pattern from `light`; 1 = on.
- `max_level`  in  PWM_BITS: brightness target for on bits.
- `led_out`  out  N_LED: registered PWM output, to `ledr`.
- `busy`  out  1: high while any channel level ≠ its target.

## Operation
- Per-channel `level[i]` register, PWM_BITS wide.
- Target: `tgt[i] = led_in[i] ? max_level : 0`.
- Prescaler `pre` counts 0..PRESCALE-1 and wraps; `tick` = (`pre == PRESCALE-1`).
- On each tick, per channel:
  - if `level < tgt`: `level = min(level+FADE_STEP, tgt)`;
  - if `level > tgt`: `level = max(level-FADE_STEP, tgt)`.
  - Compute in PWM_BITS+1 bits; never overshoot, never wrap.
- PWM counter `pcnt` counts 0..2^PWM_BITS-2 and wraps; `led_out[i] <= (level[i] > pcnt)`.
  - Level 0 gives always off; level 2^PWM_BITS-1 gives always on; duty = level/(2^PWM_BITS-1).
- FSM states:
  - DISABLED: `enable`=0. Levels, `pre` and `pcnt` held at 0; `led_out`=0.
  - IDLE: all levels equal their targets.
  - FADING: some level differs from its target.
- FSM transitions:
  - Any state to DISABLED when `enable`=0.
  - DISABLED to IDLE when `enable`=1.
  - IDLE and FADING switch based on the level/target comparison, re-evaluated every cycle.
- `busy` = (state == FADING), registered.
- `led_in` or `max_level` changing mid-fade: the new target applies from the next tick. A channel may reverse direction.
- Rising and falling channels update on the same tick, independently.

## Timing
- Reset (`rst`=0): all levels 0, `pre`=0, `pcnt`=0, state IDLE, `led_out`=0, `busy`=0. These take effect immediately, asynchronously, including mid-fade.
- `led_in` and `max_level` are sampled only on tick cycles.
- Level update is visible the cycle after the tick. `led_out` reflects it one further cycle later, because the output is registered.
- Full fade 0→M takes ceil(M/FADE_STEP) ticks.
- `enable` falling: `led_out`=0 and `busy`=0 on the next edge.
- `enable` rising: the first tick occurs PRESCALE cycles later.

## Configuration
- `LED_FADER_INSYNC_EN` defined: `led_in` passes through a 2-flop synchronizer, reset to 0, before use. This adds 2 cycles of sampling latency and is intended for asynchronous pattern sources.
- `LED_FADER_INSYNC_EN` undefined: `led_in` is used directly. `light` is then required to be in the same clock domain.

## Structure
- Package `led_fader_pkg` holds:
  - the FSM state enum (DISABLED, IDLE, FADING);
  - the saturating step function;
  - default parameter constants.
- Sub-module `led_pwm_channel`, one instance per LED, generated N_LED times. It contains the level register, the step logic, and the compare against the shared `pcnt`. It outputs `led_out[i]` and a `mismatch` bit.
- The top holds the prescaler, `pcnt`, the FSM, and the OR-reduction of the `mismatch` bits into `busy`.

## Test plan
- Reset mid-fade: drop `rst` while `busy`=1 → `led_out`=0 and `busy`=0 within the same cycle. After release, levels read 0.
- Fade up with PRESCALE=4, FADE_STEP=64, `max_level`=255, `led_in`=0x0001 → level0 steps 64, 128, 192, 255 (saturated) over 4 ticks. `busy` drops after the last tick, then `led_out[0]` is constantly 1.
- Fade down: from level 255, set `led_in`=0 → levels 191, 127, 63, 0, then `led_out[0]` is constantly 0.
- Duty check with `max_level`=128 steady → `led_out[0]` high for exactly 128 of every 255 cycles.
- Simultaneous: `led_in` changes 0x0001→0x0002 at steady state → channel 0 falls and channel 1 rises on the same ticks. `busy` stays high until both finish.
- Enable drop mid-fade → `led_out`=0x0000 next cycle and levels 0. Re-enable → the first level change occurs PRESCALE cycles later.

Source files
------------

// File: rtl/led_fader_pkg.sv
// Shared definitions for the led_fader block: FSM states, default
// parameter values and the saturating fade-step helper.
package led_fader_pkg;

   localparam int DEF_N_LED     = 16;
   localparam int DEF_PWM_BITS  = 8;
   localparam int DEF_PRESCALE  = 1000;
   localparam int DEF_FADE_STEP = 8;

   // Widest brightness supported by sat_step; PWM_BITS must not exceed it.
   localparam int STEP_W = 16;

   typedef enum logic [1:0] {
      DISABLED = 2'd0,
      IDLE     = 2'd1,
      FADING   = 2'd2
   } fader_state_e;

   // Move level toward tgt by at most step, landing exactly on tgt
   // instead of overshooting; the rising sum carries one guard bit.
   function automatic logic [STEP_W-1:0] sat_step(
      input logic [STEP_W-1:0] level,
      input logic [STEP_W-1:0] tgt,
      input logic [STEP_W-1:0] step
   );
      logic [STEP_W:0]   sum;
      logic [STEP_W-1:0] res;
      sum = {1'b0, level} + {1'b0, step};
      res = level;
      if (level < tgt) begin
         res = (sum > {1'b0, tgt}) ? tgt : sum[STEP_W-1:0];
      end else if (level > tgt) begin
         res = ((level - tgt) <= step) ? tgt : (level - step);
      end else begin
         res = level;
      end
      return res;
   endfunction

endpackage

// File: rtl/led_fader_channel.sv
// led_pwm_channel: one LED's brightness level, its fade stepping and the
// PWM compare against the shared counter. Output pin is registered.
module led_pwm_channel
   import led_fader_pkg::*;
#(
   parameter int PWM_BITS  = DEF_PWM_BITS,
   parameter int FADE_STEP = DEF_FADE_STEP
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr_i,
   input  logic                tick_i,
   input  logic                led_in_i,
   input  logic [PWM_BITS-1:0] max_level_i,
   input  logic [PWM_BITS-1:0] pcnt_i,
   output logic                led_out_o,
   output logic                mismatch_o
);

   logic [PWM_BITS-1:0] tgt_s;
   logic [PWM_BITS-1:0] level_q;
   logic [PWM_BITS-1:0] level_d;
   logic                led_q;
   logic                led_d;

   assign tgt_s      = led_in_i ? max_level_i : '0;
   assign mismatch_o = (level_q != tgt_s);
   assign led_out_o  = led_q;

   // Next level: cleared while disabled, stepped toward target on ticks.
   always_comb begin
      level_d = level_q;
      led_d   = 1'b0;
      if (clr_i) begin
         level_d = '0;
         led_d   = 1'b0;
      end else begin
         led_d = (level_q > pcnt_i);
         if (tick_i) begin
            level_d = PWM_BITS'(sat_step(STEP_W'(level_q), STEP_W'(tgt_s),
                                         STEP_W'(FADE_STEP)));
         end else begin
            level_d = level_q;
         end
      end
   end

   // Level and PWM output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         level_q <= '0;
         led_q   <= 1'b0;
      end else begin
         level_q <= level_d;
         led_q   <= led_d;
      end
   end

endmodule

// File: rtl/led_fader.sv
// led_fader: per-LED brightness fader and PWM driver for the board LEDs.
// Holds the fade prescaler, the shared PWM counter and the
// DISABLED/IDLE/FADING FSM. Optional macro LED_FADER_INSYNC_EN adds a
// 2-flop synchronizer on led_in for asynchronous pattern sources.
module led_fader
   import led_fader_pkg::*;
#(
   parameter int N_LED     = DEF_N_LED,
   parameter int PWM_BITS  = DEF_PWM_BITS,
   parameter int PRESCALE  = DEF_PRESCALE,
   parameter int FADE_STEP = DEF_FADE_STEP
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [N_LED-1:0]    led_in,
   input  logic [PWM_BITS-1:0] max_level,
   output logic [N_LED-1:0]    led_out,
   output logic                busy
);

   localparam int                  PRE_W    = $clog2(PRESCALE);
   localparam logic [PRE_W-1:0]    PRE_MAX  = PRE_W'(PRESCALE - 1);
   // PWM period is 2^PWM_BITS-1 so that the full-scale level is always on.
   localparam logic [PWM_BITS-1:0] PCNT_MAX = PWM_BITS'((1 << PWM_BITS) - 2);

   logic [N_LED-1:0]    led_use_s;
   logic [N_LED-1:0]    led_s;
   logic [N_LED-1:0]    mismatch_s;
   logic                tick_s;
   logic [PRE_W-1:0]    pre_q;
   logic [PRE_W-1:0]    pre_d;
   logic [PWM_BITS-1:0] pcnt_q;
   logic [PWM_BITS-1:0] pcnt_d;
   fader_state_e        state_q;
   fader_state_e        state_d;

`ifdef LED_FADER_INSYNC_EN
   logic [N_LED-1:0] sync1_q;
   logic [N_LED-1:0] sync2_q;

   // Two-stage synchronizer for an asynchronous led_in source.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= led_in;
         sync2_q <= sync1_q;
      end
   end

   assign led_use_s = sync2_q;
`else
   assign led_use_s = led_in;
`endif

   assign tick_s = enable && (pre_q == PRE_MAX);

   // Prescaler and PWM counter advance; both held at zero while disabled.
   always_comb begin
      pre_d  = '0;
      pcnt_d = '0;
      if (!enable) begin
         pre_d  = '0;
         pcnt_d = '0;
      end else begin
         pre_d  = (pre_q == PRE_MAX) ? '0 : (pre_q + PRE_W'(1));
         pcnt_d = (pcnt_q == PCNT_MAX) ? '0 : (pcnt_q + PWM_BITS'(1));
      end
   end

   // FSM next state: enable dominates, otherwise track level/target match.
   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = DISABLED;
      end else begin
         case (state_q)
            DISABLED: state_d = IDLE;
            IDLE:     state_d = (|mismatch_s) ? FADING : IDLE;
            FADING:   state_d = (|mismatch_s) ? FADING : IDLE;
            default:  state_d = IDLE;
         endcase
      end
   end

   // Counter and FSM state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre_q   <= '0;
         pcnt_q  <= '0;
         state_q <= IDLE;
      end else begin
         pre_q   <= pre_d;
         pcnt_q  <= pcnt_d;
         state_q <= state_d;
      end
   end

   for (genvar i = 0; i < N_LED; i++) begin : g_ch
      led_pwm_channel #(
         .PWM_BITS  (PWM_BITS),
         .FADE_STEP (FADE_STEP)
      ) u_ch (
         .clk         (clk),
         .rst         (rst),
         .clr_i       (!enable),
         .tick_i      (tick_s),
         .led_in_i    (led_use_s[i]),
         .max_level_i (max_level),
         .pcnt_i      (pcnt_q),
         .led_out_o   (led_s[i]),
         .mismatch_o  (mismatch_s[i])
      );
   end

   assign led_out = led_s;
   assign busy    = (state_q == FADING);

endmodule

// File: tb/tb_led_fader.sv
// Scoreboard bench for led_fader: a driver applies directed then random
// stimulus each cycle, a reference model predicts led_out/busy after the
// next edge and queues it; a monitor pops and compares after every edge.
module tb_led_fader;

   localparam int N    = 16;
   localparam int P    = 4;
   localparam int FS   = 64;
   localparam int PER  = 255;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [15:0] led_in;
   logic [7:0]  max_level;
   logic [15:0] led_out;
   logic        busy;

   always #5 clk = ~clk;

   led_fader #(
      .N_LED     (N),
      .PWM_BITS  (8),
      .PRESCALE  (P),
      .FADE_STEP (FS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .led_in    (led_in),
      .max_level (max_level),
      .led_out   (led_out),
      .busy      (busy)
   );

   typedef struct packed {
      logic [15:0] led;
      logic        busy;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   passes = 0;

   // reference model: brightness per LED, cycles within fade tick,
   // position within PWM period, whether we just came out of disable
   int          m_lvl[N];
   int          m_phase;
   int          m_pwm;
   bit          m_dis;
   bit          m_busy;
   logic [15:0] m_led;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
   endtask

   task automatic model_clear(input bit dis);
      for (int i = 0; i < N; i++) m_lvl[i] = 0;
      m_phase = 0;
      m_pwm   = 0;
      m_led   = '0;
      m_busy  = 1'b0;
      m_dis   = dis;
   endtask

   // Predict outputs after the coming rising edge from the present inputs.
   task automatic model_step();
      int          tgt;
      bit          differ;
      logic [15:0] nl;
      if (!rst) begin
         model_clear(1'b0);
      end else if (!enable) begin
         model_clear(1'b1);
      end else begin
         differ = 1'b0;
         nl     = '0;
         for (int i = 0; i < N; i++) begin
            tgt   = led_in[i] ? int'(max_level) : 0;
            nl[i] = (m_lvl[i] > m_pwm);
            if (m_lvl[i] != tgt) differ = 1'b1;
         end
         m_busy = m_dis ? 1'b0 : differ;
         m_dis  = 1'b0;
         if (m_phase == P - 1) begin
            for (int i = 0; i < N; i++) begin
               tgt = led_in[i] ? int'(max_level) : 0;
               if (m_lvl[i] < tgt)      m_lvl[i] = (m_lvl[i] + FS > tgt) ? tgt : m_lvl[i] + FS;
               else if (m_lvl[i] > tgt) m_lvl[i] = (m_lvl[i] - FS < tgt) ? tgt : m_lvl[i] - FS;
            end
         end
         m_phase = (m_phase + 1) % P;
         m_pwm   = (m_pwm + 1) % PER;
         m_led   = nl;
      end
      exp_q.push_back('{led: m_led, busy: m_busy});
   endtask

   task automatic cyc(input bit r, input bit e, input logic [15:0] li, input logic [7:0] ml);
      @(negedge clk);
      rst       = r;
      enable    = e;
      led_in    = li;
      max_level = ml;
      model_step();
      if (!r) begin
         #1;
         chk("rst_led_out_immediate", 32'(led_out), 32'd0);
         chk("rst_busy_immediate", 32'(busy), 32'd0);
      end
   endtask

   // Monitor: after each rising edge compare DUT outputs to the oldest prediction.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("led_out", 32'(led_out), 32'(e.led));
            chk("busy", 32'(busy), 32'(e.busy));
         end
      end
   end

   // Driver: directed scenarios followed by randomized traffic.
   initial begin
      int          hi;
      int          guard;
      bit          r;
      bit          e;
      logic [15:0] li;
      logic [7:0]  ml;
      rst       = 1'b0;
      enable    = 1'b1;
      led_in    = '0;
      max_level = '0;
      model_clear(1'b0);

      repeat (3) cyc(1'b0, 1'b1, 16'h0000, 8'd0);
      // fade up channel 0 to full scale, then hold
      repeat (40) cyc(1'b1, 1'b1, 16'h0001, 8'd255);
      // fade down
      repeat (40) cyc(1'b1, 1'b1, 16'h0000, 8'd255);
      // simultaneous fall on 0, rise on 1
      repeat (30) cyc(1'b1, 1'b1, 16'h0001, 8'd255);
      repeat (40) cyc(1'b1, 1'b1, 16'h0002, 8'd255);
      // duty at half scale
      repeat (40) cyc(1'b1, 1'b1, 16'h0001, 8'd128);
      hi = 0;
      for (int k = 0; k < PER; k++) begin
         cyc(1'b1, 1'b1, 16'h0001, 8'd128);
         hi += int'(led_out[0]);
      end
      chk("duty_128_of_255", 32'(hi), 32'd128);
      // enable drop mid-fade, then re-enable
      repeat (6)  cyc(1'b1, 1'b1, 16'hFFFF, 8'd200);
      repeat (3)  cyc(1'b1, 1'b0, 16'hFFFF, 8'd200);
      repeat (30) cyc(1'b1, 1'b1, 16'hFFFF, 8'd200);
      // reset mid-fade
      repeat (30) cyc(1'b1, 1'b1, 16'h0000, 8'd200);
      repeat (7)  cyc(1'b1, 1'b1, 16'hA5A5, 8'd255);
      chk("busy_before_reset", 32'(busy), 32'd1);
      repeat (2)  cyc(1'b0, 1'b1, 16'hA5A5, 8'd255);
      repeat (30) cyc(1'b1, 1'b1, 16'hA5A5, 8'd255);

      // random traffic
      li = 16'h0000;
      ml = 8'd255;
      for (int k = 0; k < 3000; k++) begin
         r = ($urandom_range(0, 399) != 0);
         e = ($urandom_range(0, 79) != 0);
         if ($urandom_range(0, 24) == 0) li = 16'($urandom());
         if ($urandom_range(0, 39) == 0) ml = 8'($urandom());
         cyc(r, e, li, ml);
      end

      guard = 0;
      while (exp_q.size() > 0 && guard < 100) begin
         @(posedge clk);
         guard++;
      end
      #5;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
